// File: rtl/freq_meter.sv
// Gated frequency counter: counts Schmitt-filtered rising crossings of a sampled
// voltage over a fixed window of GATE_CYCLES clocks, then publishes the count.
`ifndef OSC_WIDTH
`define OSC_WIDTH 32
`endif
`ifndef OSC_DEPTH
`define OSC_DEPTH 12
`endif

module freq_meter #(
  parameter int OSC_WIDTH   = `OSC_WIDTH,
  parameter int OSC_DEPTH   = `OSC_DEPTH,
  parameter int GATE_CYCLES = 100000000,
  parameter int HYST        = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [OSC_DEPTH-1:0] v,
  output logic [OSC_WIDTH-1:0] f,
  output logic                 f_valid,
  output logic                 overflow
);

  localparam int MID = 2 ** (OSC_DEPTH - 1);
  localparam int THR_HI = MID + HYST;
  localparam int THR_LO = MID - HYST;
  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [OSC_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, MEASURE} state_e;

  state_e                 state_q, state_d;
  logic [OSC_DEPTH-1:0]   v_q;
  logic                   sq_q, sq_d, sq_prev_q;
  logic [GW-1:0]          gate_q, gate_d;
  logic [OSC_WIDTH-1:0]   edge_q, edge_d;
  logic [OSC_WIDTH-1:0]   f_q, f_d;
  logic                   f_valid_q, f_valid_d;
  logic                   ovf_q, ovf_d;
  logic                   edge_det;
  logic [OSC_WIDTH-1:0]   edge_sat;

  // Schmitt trigger on the registered sample; it runs in every state so the
  // history is settled before a window opens.
  always_comb begin
    sq_d = sq_q;
    if (int'(v_q) >= THR_HI)      sq_d = 1'b1;
    else if (int'(v_q) <= THR_LO) sq_d = 1'b0;
  end

  assign edge_det = sq_q & ~sq_prev_q;
  assign edge_sat = (edge_det && (edge_q != CNT_MAX)) ? edge_q + OSC_WIDTH'(1) : edge_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q       <= '0;
      sq_q      <= 1'b0;
      sq_prev_q <= 1'b0;
    end else begin
      v_q       <= v;
      sq_q      <= sq_d;
      sq_prev_q <= sq_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en)  state_d = MEASURE;
      MEASURE: if (!en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters clear whenever no window is running; the terminal cycle closes the
  // window (its own edge included) and restarts the next one with no gap.
  always_comb begin
    gate_d    = '0;
    edge_d    = '0;
    f_d       = f_q;
    ovf_d     = ovf_q;
    f_valid_d = 1'b0;
    if (state_q == MEASURE && en) begin
      if (gate_q == GATE_LAST) begin
        f_d       = edge_sat;
        ovf_d     = (edge_sat == CNT_MAX);
        f_valid_d = 1'b1;
      end else begin
        gate_d = gate_q + GW'(1);
        edge_d = edge_sat;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate_q    <= '0;
      edge_q    <= '0;
      f_q       <= '0;
      f_valid_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      gate_q    <= gate_d;
      edge_q    <= edge_d;
      f_q       <= f_d;
      f_valid_q <= f_valid_d;
      ovf_q     <= ovf_d;
    end
  end

  assign f        = f_q;
  assign f_valid  = f_valid_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (12-bit and saturating 4-bit result) share
// one randomized stimulus; a window-level model feeds per-instance scoreboards.
module tb_freq_meter;
  localparam int G   = 1000;
  localparam int HY  = 8;
  localparam int MID = 128;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [7:0] v;
  logic [11:0] f12;
  logic        fv12, ov12;
  logic [3:0]  f4;
  logic        fv4, ov4;

  always #5 clk = ~clk;

  freq_meter #(.OSC_WIDTH(12), .OSC_DEPTH(8), .GATE_CYCLES(G), .HYST(HY)) dut12 (
    .clk(clk), .rst(rst), .en(en), .v(v), .f(f12), .f_valid(fv12), .overflow(ov12));
  freq_meter #(.OSC_WIDTH(4), .OSC_DEPTH(8), .GATE_CYCLES(G), .HYST(HY)) dut4 (
    .clk(clk), .rst(rst), .en(en), .v(v), .f(f4), .f_valid(fv4), .overflow(ov4));

  typedef struct {int cyc; int f; bit ovf;} exp_t;
  exp_t q12[$], q4[$];

  int cyc = 0, ws = 0, ph = 0, stim_to = 0;
  bit st = 0, done = 0;
  int n_vec = 0, n_err = 0;

  // Reference: Schmitt state of the sample seen two edges back, rising events
  // timestamped by the edge at which they are counted, windows as cycle ranges.
  initial begin
    bit sq1 = 0, sq2 = 0, nsq;
    int vlast = 0, cnt;
    int edges[$];
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        st = 0; sq1 = 0; sq2 = 0; vlast = 0; edges.delete();
      end else begin
        if (sq1 && !sq2) edges.push_back(cyc);
        nsq = (vlast >= MID + HY) ? 1'b1 : (vlast <= MID - HY) ? 1'b0 : sq1;
        sq2 = sq1; sq1 = nsq; vlast = int'(v);
        if (!st) begin
          if (en) begin st = 1; ws = cyc + 1; edges.delete(); end
        end else if (!en) begin
          st = 0;
        end else if (cyc - ws + 1 == G) begin
          cnt = 0;
          foreach (edges[i]) if (edges[i] >= ws) cnt++;
          q12.push_back('{cyc, (cnt > 4095) ? 4095 : cnt, cnt >= 4095});
          q4.push_back('{cyc, (cnt > 15) ? 15 : cnt, cnt >= 15});
          ws = cyc + 1;
          edges.delete();
        end
      end
    end
  end

  task automatic chk(input string nm, input bit fv, input int fa, input bit oa,
                     input bit have, input exp_t e, inout int hf, inout bit ho,
                     output bit pop);
    pop = 0;
    if (rst) begin
      n_vec++;
      if (fv || fa != 0 || oa) begin
        n_err++;
        $display("FAIL %s reset @%0d: f_valid=%0d f=%0d overflow=%0d, want 0/0/0", nm, cyc, fv, fa, oa);
      end
      hf = 0; ho = 0;
      return;
    end
    if (fv) begin
      n_vec++;
      if (!have) begin
        n_err++;
        $display("FAIL %s unexpected f_valid @%0d: f=%0d overflow=%0d, want no pulse", nm, cyc, fa, oa);
      end else begin
        pop = 1;
        if (e.cyc != cyc || e.f != fa || e.ovf != oa) begin
          n_err++;
          $display("FAIL %s result: cycle=%0d f=%0d overflow=%0d, want cycle=%0d f=%0d overflow=%0d",
                   nm, cyc, fa, oa, e.cyc, e.f, e.ovf);
        end
        hf = e.f; ho = e.ovf;
      end
    end else if (have && e.cyc <= cyc) begin
      n_vec++; n_err++; pop = 1;
      $display("FAIL %s missing f_valid: none @%0d, want pulse @%0d f=%0d", nm, cyc, e.cyc, e.f);
    end
    n_vec++;
    if (fa != hf || oa != ho) begin
      n_err++;
      $display("FAIL %s hold @%0d: f=%0d overflow=%0d, want f=%0d overflow=%0d", nm, cyc, fa, oa, hf, ho);
    end
  endtask

  // Monitor: samples just after each rising edge, independent of stimulus.
  initial begin
    exp_t e;
    bit have, pop;
    int hf12 = 0, hf4 = 0;
    bit ho12 = 0, ho4 = 0;
    forever begin
      @(posedge clk);
      #1;
      if (done) begin
        n_vec++;
        if (q12.size() != 0 || q4.size() != 0) begin
          n_err++;
          $display("FAIL drain: %0d/%0d results outstanding, want 0/0", q12.size(), q4.size());
        end
        n_vec++;
        if (stim_to != 0) begin
          n_err++;
          $display("FAIL window_sync: %0d positioning timeouts, want 0", stim_to);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
      end
      have = q12.size() > 0;
      if (have) e = q12[0];
      chk("w12", fv12, int'(f12), ov12, have, e, hf12, ho12, pop);
      if (pop) void'(q12.pop_front());
      have = q4.size() > 0;
      if (have) e = q4[0];
      chk("w4", fv4, int'(f4), ov4, have, e, hf4, ho4, pop);
      if (pop) void'(q4.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not reach its summary, want completion");
    $fatal(1);
  end

  // mode 0 square of period per, 1 random inside hysteresis, 2 random full range,
  // 3 held low, 4 held high
  task automatic run(input int n, input int mode, input int per);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ph++;
      case (mode)
        0:       v = ((ph % per) < per / 2) ? 8'd255 : 8'd0;
        1:       v = 8'($urandom_range(135, 121));
        2:       v = 8'($urandom_range(255, 0));
        3:       v = 8'd0;
        default: v = 8'd255;
      endcase
    end
  endtask

  // Advance until the next edge is position p of a running window.
  task automatic wait_pos(input int p, input int mode, input int per);
    int k = 0;
    while (!(st && (cyc + 1 - ws) == p)) begin
      run(1, mode, per);
      k++;
      if (k > 3000) begin stim_to++; return; end
    end
  endtask

  initial begin
    int mode, per, len, r;
    rst = 1'b1; en = 1'b0; v = 8'd0;
    run(3, 3, 1);
    rst = 1'b0; en = 1'b1;
    run(3010, 0, 100);
    run(2000, 1, 1);
    run(2000, 0, 40);
    run(2000, 0, 100);
    wait_pos(500, 0, 100);
    rst = 1'b1;
    run(2, 0, 100);
    rst = 1'b0;
    run(2500, 0, 100);
    wait_pos(700, 0, 100);
    en = 1'b0;
    run(30, 0, 100);
    en = 1'b1;
    run(2500, 0, 100);
    run(10, 3, 1);
    wait_pos(G - 3, 3, 1);
    v = 8'd255;
    run(40, 4, 1);
    run(1200, 0, 100);
    for (int s = 0; s < 20; s++) begin
      mode = $urandom_range(2, 0);
      per  = $urandom_range(200, 4);
      len  = $urandom_range(1500, 200);
      r    = $urandom_range(9, 0);
      if (r == 0) begin
        rst = 1'b1;
        run(2, mode, per);
        rst = 1'b0;
      end else if (r < 3) begin
        en = 1'b0;
        run($urandom_range(50, 1), mode, per);
        en = 1'b1;
      end
      run(len, mode, per);
    end
    run(5, 3, 1);
    done = 1'b1;
  end

endmodule
